key_cmd_ctrl: RTL and testbench

Turns the debounced levels of up to NUM_KEYS push-buttons into a single stream of key commands for the analyzer control logic. Each key has its own press-classification FSM: short press, long press, auto-repeat while held. A round-robin arbiter shares one valid/ready command port among the keys. It sits directly behind the per-key debounce instances and in front of the mode/capture control registers.

---
 rtl/key_cmd_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_key_cmd_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_ctrl.sv
// key_cmd_ctrl: per-key press classifier (SHORT / LONG / REPEAT) feeding a
// round-robin arbiter that shares one valid/ready command port.
// Each key owns a one-deep pending slot; an event that lands on an occupied,
// non-granted slot overwrites it and bumps the saturating drop counter.
module key_cmd_ctrl #(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_FREQ_HZ = 80000000,
  parameter int LONG_MS     = 800,
  parameter int REPEAT_MS   = 150
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_level,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [2:0]          cmd_key,
  output logic [1:0]          cmd_type,
  output logic [7:0]          drop_cnt
);

  localparam logic [31:0] LONG_CNT   = 32'((CLK_FREQ_HZ / 1000) * LONG_MS);
  localparam logic [31:0] REPEAT_CNT = 32'((CLK_FREQ_HZ / 1000) * REPEAT_MS);
  localparam logic [2:0]  LAST_KEY   = 3'(NUM_KEYS - 1);

  localparam logic [1:0] T_SHORT  = 2'b01;
  localparam logic [1:0] T_LONG   = 2'b10;
  localparam logic [1:0] T_REPEAT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_HELD    = 2'd2
  } state_t;

  state_t                st [NUM_KEYS];
  logic [31:0]           cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0]   key_prev;
  // Cleared by reset; suppresses edge detection on the first clock after
  // reset so a key already held low is not mistaken for a fresh press.
  logic                  armed;

  logic [NUM_KEYS-1:0]   ev_vld_p0;
  logic [1:0]            ev_type_p0 [NUM_KEYS];

  logic [NUM_KEYS-1:0]   pend;
  logic [1:0]            pend_type [NUM_KEYS];
  logic [2:0]            last_grant;

  logic                  load;
  logic                  gnt_any;
  logic [2:0]            gnt_idx;
  logic [1:0]            gnt_type;
  logic [NUM_KEYS-1:0]   gnt_oh;
  logic [3:0]            n_drop;

  // Saturating add for the drop counter.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign load = !cmd_valid || cmd_ready;

  // Stage p0: classify each key's current state/input into an event.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      ev_vld_p0[k]  = 1'b0;
      ev_type_p0[k] = T_SHORT;
      case (st[k])
        S_PRESSED: begin
          if (key_level[k]) begin
            ev_vld_p0[k]  = 1'b1;
            ev_type_p0[k] = T_SHORT;
          end else if (cnt[k] == LONG_CNT - 32'd1) begin
            ev_vld_p0[k]  = 1'b1;
            ev_type_p0[k] = T_LONG;
          end
        end
        S_HELD: begin
          if (!key_level[k] && cnt[k] == REPEAT_CNT - 32'd1) begin
            ev_vld_p0[k]  = 1'b1;
            ev_type_p0[k] = T_REPEAT;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-key press FSMs, hold counters and edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_prev <= '1;
      armed    <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        st[k]  <= S_IDLE;
        cnt[k] <= '0;
      end
    end else begin
      key_prev <= key_level;
      armed    <= 1'b1;
      for (int k = 0; k < NUM_KEYS; k++) begin
        case (st[k])
          S_IDLE: begin
            if (armed && key_prev[k] && !key_level[k]) begin
              st[k]  <= S_PRESSED;
              cnt[k] <= '0;
            end
          end
          S_PRESSED: begin
            if (key_level[k]) begin
              st[k] <= S_IDLE;
            end else if (cnt[k] == LONG_CNT - 32'd1) begin
              st[k]  <= S_HELD;
              cnt[k] <= '0;
            end else begin
              cnt[k] <= cnt[k] + 32'd1;
            end
          end
          S_HELD: begin
            if (key_level[k]) begin
              st[k] <= S_IDLE;
            end else if (cnt[k] == REPEAT_CNT - 32'd1) begin
              cnt[k] <= '0;
            end else begin
              cnt[k] <= cnt[k] + 32'd1;
            end
          end
          default: st[k] <= S_IDLE;
        endcase
      end
    end
  end

  // Round-robin pick: smallest upward distance from last_grant+1 among pending keys.
  always_comb begin
    int d;
    int best;
    d        = 0;
    best     = NUM_KEYS;
    gnt_any  = 1'b0;
    gnt_idx  = 3'd0;
    gnt_type = T_SHORT;
    for (int k = 0; k < NUM_KEYS; k++) begin
      d = (k + NUM_KEYS - 1 - int'(last_grant)) % NUM_KEYS;
      if (pend[k] && d < best) begin
        best     = d;
        gnt_any  = 1'b1;
        gnt_idx  = 3'(k);
        gnt_type = pend_type[k];
      end
    end
  end

  // One-hot grant (only when the output register actually loads) and drop tally.
  always_comb begin
    n_drop = 4'd0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      gnt_oh[k] = load && gnt_any && (gnt_idx == 3'(k));
      if (ev_vld_p0[k] && pend[k] && !gnt_oh[k]) begin
        n_drop = n_drop + 4'd1;
      end
    end
  end

  // Stage p1: pending-slot flags, drop counter, arbiter state and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      drop_cnt   <= 8'd0;
      last_grant <= LAST_KEY;
      cmd_valid  <= 1'b0;
      cmd_key    <= 3'd0;
      cmd_type   <= 2'b00;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (ev_vld_p0[k]) begin
          pend[k] <= 1'b1;
        end else if (gnt_oh[k]) begin
          pend[k] <= 1'b0;
        end
      end
      drop_cnt <= sat_add8(drop_cnt, n_drop);
      if (load) begin
        if (gnt_any) begin
          cmd_valid  <= 1'b1;
          cmd_key    <= gnt_idx;
          cmd_type   <= gnt_type;
          last_grant <= gnt_idx;
        end else begin
          cmd_valid  <= 1'b0;
        end
      end
    end
  end

  // Pending event types are pure data; pend[] qualifies them, so no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (ev_vld_p0[k]) begin
        pend_type[k] <= ev_type_p0[k];
      end
    end
  end

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Scoreboard bench for key_cmd_ctrl with small timing parameters
// (LONG_CNT = 8, REPEAT_CNT = 3).
module tb_key_cmd_ctrl;

  localparam int NK = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_level = '1;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [2:0]    cmd_key;
  logic [1:0]    cmd_type;
  logic [7:0]    drop_cnt;

  key_cmd_ctrl #(
    .NUM_KEYS(NK), .CLK_FREQ_HZ(1000), .LONG_MS(8), .REPEAT_MS(3)
  ) dut (
    .clk(clk), .rst(rst), .key_level(key_level),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .cmd_type(cmd_type), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] key;
    logic [1:0] typ;
    int         at;   // expected monitor cycle, -1 = not checked
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [1:0] t, input int at);
    exp_t e;
    e.key = k; e.typ = t; e.at = at;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    sb.delete();
    rst = 1'b0;
    repeat (3) step();
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall stability.
  logic       prev_stall = 1'b0;
  logic [2:0] pk = 3'd0;
  logic [1:0] pt = 2'd0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_tests++;
        if (!(cmd_valid === 1'b1 && cmd_key === pk && cmd_type === pt)) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b key=%0d type=%0d expected v=1 key=%0d type=%0d",
                   cmd_valid, cmd_key, cmd_type, pk, pt);
        end
      end
      if (cmd_valid && cmd_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_cmd: got key=%0d type=%0d at cyc %0d expected none",
                   cmd_key, cmd_type, cyc);
        end else begin
          e = sb.pop_front();
          if (cmd_key !== e.key || cmd_type !== e.typ || (e.at >= 0 && cyc != e.at)) begin
            n_fail++;
            $display("FAIL cmd: got key=%0d type=%0d cyc=%0d expected key=%0d type=%0d cyc=%0d",
                     cmd_key, cmd_type, cyc, e.key, e.typ, e.at);
          end
        end
      end
      prev_stall = cmd_valid && !cmd_ready;
      pk = cmd_key;
      pt = cmd_type;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int r;

    // Reset state
    #1;
    check("rst_valid", cmd_valid, 0);
    check("rst_key", cmd_key, 0);
    check("rst_type", cmd_type, 0);
    check("rst_drop", drop_cnt, 0);
    do_reset();

    // Short press on key 2: low 4 cycles, release sampled at E0+4
    cmd_ready = 1'b1;
    e0 = cyc + 1;
    push(3'd2, 2'b01, e0 + 5);
    key_level[2] = 1'b0;
    repeat (4) step();
    key_level[2] = 1'b1;
    repeat (8) step();
    check("short_drained", sb.size(), 0);

    // Long press with repeats on key 0: low 18 cycles
    e0 = cyc + 1;
    push(3'd0, 2'b10, e0 + 9);
    push(3'd0, 2'b11, e0 + 12);
    push(3'd0, 2'b11, e0 + 15);
    push(3'd0, 2'b11, e0 + 18);
    key_level[0] = 1'b0;
    repeat (18) step();
    key_level[0] = 1'b1;
    repeat (10) step();
    check("long_drained", sb.size(), 0);
    check("long_drop", drop_cnt, 0);

    // Round robin: keys 0,1,3 release together while stalled
    do_reset();
    cmd_ready = 1'b0;
    key_level = 4'b0100;
    repeat (2) step();
    key_level = 4'b1111;
    repeat (7) step();
    check("rr_stalled_valid", cmd_valid, 1);
    check("rr_stalled_key", cmd_key, 0);
    r = cyc;
    push(3'd0, 2'b01, r);
    push(3'd1, 2'b01, r + 1);
    push(3'd3, 2'b01, r + 2);
    cmd_ready = 1'b1;
    repeat (6) step();
    check("rr_drop", drop_cnt, 0);
    check("rr_drained", sb.size(), 0);

    // Overwrite: three short presses of key 1 while stalled
    do_reset();
    cmd_ready = 1'b0;
    repeat (3) begin
      key_level[1] = 1'b0;
      repeat (2) step();
      key_level[1] = 1'b1;
      repeat (2) step();
    end
    step();
    check("ovw_drop", drop_cnt, 1);
    check("ovw_key", cmd_key, 1);
    check("ovw_type", cmd_type, 1);
    r = cyc;
    push(3'd1, 2'b01, r);
    push(3'd1, 2'b01, r + 1);
    cmd_ready = 1'b1;
    repeat (5) step();
    check("ovw_drained", sb.size(), 0);
    check("ovw_drop_after", drop_cnt, 1);

    // Reset mid-press and mid-handshake
    do_reset();
    cmd_ready = 1'b0;
    repeat (3) begin
      key_level[2] = 1'b0;
      repeat (2) step();
      key_level[2] = 1'b1;
      repeat (2) step();
    end
    step();
    check("pre_rst_drop", drop_cnt, 1);
    key_level[0] = 1'b0;
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", cmd_valid, 0);
    check("arst_key", cmd_key, 0);
    check("arst_type", cmd_type, 0);
    check("arst_drop", drop_cnt, 0);
    sb.delete();
    step();
    rst = 1'b0;
    cmd_ready = 1'b1;
    repeat (20) step();
    key_level[0] = 1'b1;
    repeat (15) step();
    check("arst_no_cmd", cmd_valid, 0);
    check("arst_drained", sb.size(), 0);

    // Grant of key 3's pending LONG coincides with its REPEAT
    do_reset();
    cmd_ready = 1'b0;
    key_level[1] = 1'b0;
    repeat (2) step();
    key_level[1] = 1'b1;
    repeat (3) step();
    e0 = cyc + 1;
    key_level[3] = 1'b0;
    while (cyc < e0 + 10) step();
    push(3'd1, 2'b01, e0 + 10);
    push(3'd3, 2'b10, e0 + 11);
    push(3'd3, 2'b11, e0 + 12);
    cmd_ready = 1'b1;
    repeat (2) step();
    key_level[3] = 1'b1;
    repeat (6) step();
    check("sim_drop", drop_cnt, 0);
    check("sim_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
